// File: rtl/cordic_job_arbiter.sv
// Round-robin front end sharing one CORDIC calc unit between NUM_REQ requesters.
// Latches each granted job, waits for done or a timeout, returns a one-cycle response, then flushes the unit.
module cordic_job_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned FLUSH_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [4*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_x,
    input  logic [WIDTH*NUM_REQ-1:0] req_y,
    input  logic [WIDTH*NUM_REQ-1:0] req_z,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_result,
    output logic                     resp_err,
    output logic                     busy,
    output logic                     unit_enable,
    output logic [3:0]               unit_operation,
    output logic [WIDTH-1:0]         unit_x,
    output logic [WIDTH-1:0]         unit_y,
    output logic [WIDTH-1:0]         unit_z,
    input  logic [WIDTH-1:0]         unit_result,
    input  logic                     unit_done
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP,
        ST_FLUSH
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FL_W-1:0]      fl_q, fl_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]     resp_result_q, resp_result_d;
    logic                 resp_err_q, resp_err_d;
    logic                 busy_q, busy_d;
    logic                 unit_enable_q, unit_enable_d;
    logic [3:0]           unit_op_q, unit_op_d;
    logic [WIDTH-1:0]     unit_x_q, unit_x_d;
    logic [WIDTH-1:0]     unit_y_q, unit_y_d;
    logic [WIDTH-1:0]     unit_z_q, unit_z_d;

    logic                 gnt_found;
    logic [PTR_W-1:0]     gnt_idx;
    logic [3:0]           gnt_op;
    logic [WIDTH-1:0]     gnt_x, gnt_y, gnt_z;

    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Nearest valid requester after rr_ptr wins; scanning far-to-near lets the nearest overwrite.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (((int'(rr_ptr_q) + k) % int'(NUM_REQ)) == i && req_valid[i]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PTR_W'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_op = '0;
        gnt_x  = '0;
        gnt_y  = '0;
        gnt_z  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                gnt_op = req_op[i*4 +: 4];
                gnt_x  = req_x[i*WIDTH +: WIDTH];
                gnt_y  = req_y[i*WIDTH +: WIDTH];
                gnt_z  = req_z[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= PTR_W'(NUM_REQ - 1);
            cnt_q         <= '0;
            fl_q          <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
            busy_q        <= 1'b0;
            unit_enable_q <= 1'b0;
            unit_op_q     <= 4'b1111;
            unit_x_q      <= '0;
            unit_y_q      <= '0;
            unit_z_q      <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            fl_q          <= fl_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_err_q    <= resp_err_d;
            busy_q        <= busy_d;
            unit_enable_q <= unit_enable_d;
            unit_op_q     <= unit_op_d;
            unit_x_q      <= unit_x_d;
            unit_y_q      <= unit_y_d;
            unit_z_q      <= unit_z_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        fl_d          = fl_q;
        resp_valid_d  = '0;
        resp_result_d = resp_result_q;
        resp_err_d    = resp_err_q;
        unit_enable_d = unit_enable_q;
        unit_op_d     = unit_op_q;
        unit_x_d      = unit_x_q;
        unit_y_d      = unit_y_q;
        unit_z_d      = unit_z_q;
        req_ready     = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    req_ready = NUM_REQ'(1) << gnt_idx;
                    rr_ptr_d  = gnt_idx;
                    unit_op_d = gnt_op;
                    unit_x_d  = gnt_x;
                    unit_y_d  = gnt_y;
                    unit_z_d  = gnt_z;
                    cnt_d     = '0;
                    if (op_supported(gnt_op)) begin
                        unit_enable_d = 1'b1;
                        state_d       = ST_RUN;
                    end else begin
                        // Unsupported codes are answered immediately and never reach the unit.
                        resp_valid_d  = NUM_REQ'(1) << gnt_idx;
                        resp_result_d = '0;
                        resp_err_d    = 1'b1;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_RUN: begin
                if (unit_done) begin
                    resp_valid_d  = NUM_REQ'(1) << rr_ptr_q;
                    resp_result_d = unit_result;
                    resp_err_d    = 1'b0;
                    unit_enable_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_valid_d  = NUM_REQ'(1) << rr_ptr_q;
                    resp_result_d = '0;
                    resp_err_d    = 1'b1;
                    unit_enable_d = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                unit_enable_d = 1'b0;
                fl_d          = '0;
                state_d       = ST_FLUSH;
            end
            ST_FLUSH: begin
                unit_enable_d = 1'b0;
                if (fl_q == FL_W'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    fl_d = fl_q + FL_W'(1);
                end
            end
            default: begin
                unit_enable_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign resp_valid     = resp_valid_q;
    assign resp_result    = resp_result_q;
    assign resp_err       = resp_err_q;
    assign busy           = busy_q;
    assign unit_enable    = unit_enable_q;
    assign unit_operation = unit_op_q;
    assign unit_x         = unit_x_q;
    assign unit_y         = unit_y_q;
    assign unit_z         = unit_z_q;

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Directed bench for cordic_job_arbiter with a simple latency-programmable calc unit stand-in.
module tb_cordic_job_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int WIDTH          = 32;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int FLUSH_CYCLES   = 2;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [4*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_x;
    logic [WIDTH*NUM_REQ-1:0] req_y;
    logic [WIDTH*NUM_REQ-1:0] req_z;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_result;
    logic                     resp_err;
    logic                     busy;
    logic                     unit_enable;
    logic [3:0]               unit_operation;
    logic [WIDTH-1:0]         unit_x;
    logic [WIDTH-1:0]         unit_y;
    logic [WIDTH-1:0]         unit_z;
    logic [WIDTH-1:0]         unit_result;
    logic                     unit_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int resp_count = 0;
    bit en_seen = 0;
    logic [NUM_REQ-1:0] r_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_err;

    // Calc unit stand-in: done after lat enabled cycles, MULT is Q16.16 x*z.
    int  lat = 4;
    bit  tie_low = 0;
    bit  hold_done = 0;
    int  ucnt = 0;
    logic signed [63:0] prod;

    cordic_job_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err),
        .busy(busy), .unit_enable(unit_enable), .unit_operation(unit_operation),
        .unit_x(unit_x), .unit_y(unit_y), .unit_z(unit_z),
        .unit_result(unit_result), .unit_done(unit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst || !unit_enable) ucnt <= 0;
        else                     ucnt <= ucnt + 1;
    end

    assign unit_done = hold_done || (!tie_low && unit_enable && (ucnt == lat - 1));

    always_comb begin
        prod = 64'($signed(unit_x)) * 64'($signed(unit_z));
        if (unit_operation == 4'd7) unit_result = prod[47:16];
        else                        unit_result = unit_x ^ unit_z ^ 32'hA5A5_0000;
    end

    always @(negedge clk) begin
        if (resp_valid != '0) resp_count <= resp_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (unit_enable) en_seen = 1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        hold_done = 0;
        tie_low   = 0;
        tick();
        tick();
        rst     = 1'b0;
        en_seen = 0;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] z);
        req_op[i*4 +: 4]        = op;
        req_x[i*WIDTH +: WIDTH] = x;
        req_y[i*WIDTH +: WIDTH] = y;
        req_z[i*WIDTH +: WIDTH] = z;
    endtask

    // Returns the granted requester; acc_cyc is the cycle whose closing edge accepted the job.
    task automatic wait_accept(output int g);
        bit got;
        got = 0;
        g   = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            #1;
            if ((req_ready & req_valid) != '0) begin
                for (int j = 0; j < NUM_REQ; j++) if (req_ready[j]) g = j;
                acc_cyc = cyc;
                got = 1;
            end
            tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_wait: no grant within 300 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_resp(output int rcyc);
        bit got;
        got  = 0;
        rcyc = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            if (resp_valid != '0) begin
                rcyc     = cyc;
                r_valid  = resp_valid;
                r_result = resp_result;
                r_err    = resp_err;
                got = 1;
            end else begin
                tick();
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_wait: no response within 300 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (unit_operation !== 4'b1111) begin errors++; $display("FAIL rst_op: got %b want 1111", unit_operation); end
        checks++; if (unit_enable !== 1'b0) begin errors++; $display("FAIL rst_enable: got %b want 0", unit_enable); end
        checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rst_resp_valid: got %b want 0000", resp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready_idle: got %b want 0000", req_ready); end
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_first_grant: got %b want 0010", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single_job();
        int g, rc;
        do_reset();
        lat = 18;
        set_req(0, 4'd7, 32'h0002_0000, 32'h0, 32'h0003_0000);
        req_valid = 4'b0001;
        wait_accept(g);
        req_valid = '0;
        checks++; if (g !== 0) begin errors++; $display("FAIL single_grant: got %0d want 0", g); end
        checks++; if (unit_enable !== 1'b1) begin errors++; $display("FAIL single_enable: got %b want 1", unit_enable); end
        checks++; if (unit_operation !== 4'd7) begin errors++; $display("FAIL single_op: got %0d want 7", unit_operation); end
        checks++; if (unit_x !== 32'h0002_0000 || unit_z !== 32'h0003_0000) begin
            errors++; $display("FAIL single_operands: got x=%h z=%h want 00020000 00030000", unit_x, unit_z);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        wait_resp(rc);
        checks++; if (rc - acc_cyc !== 19) begin errors++; $display("FAIL single_latency: got %0d want 19", rc - acc_cyc); end
        checks++; if (r_valid !== 4'b0001) begin errors++; $display("FAIL single_owner: got %b want 0001", r_valid); end
        checks++; if (r_result !== 32'h0006_0000) begin errors++; $display("FAIL single_result: got %h want 00060000", r_result); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", r_err); end
        tick();
        checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_pulse_width: got %b want 0000", resp_valid); end
    endtask

    task automatic test_contention();
        int g, rc, prev_rc;
        int exp_g [5] = '{0, 1, 2, 3, 0};
        logic [31:0] exp_res [4] = '{32'h0002_0000, 32'h0004_0000, 32'h0006_0000, 32'h0008_0000};
        do_reset();
        lat = 3;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'd7, 32'((i + 1) << 16), 32'h0, 32'h0002_0000);
        req_valid = 4'b1111;
        prev_rc = 0;
        for (int k = 0; k < 5; k++) begin
            wait_accept(g);
            if (k == 4) req_valid = '0;
            checks++; if (g !== exp_g[k]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, g, exp_g[k]); end
            if (k > 0) begin
                checks++; if (acc_cyc - prev_rc !== FLUSH_CYCLES + 1) begin
                    errors++; $display("FAIL rr_gap[%0d]: got %0d want %0d", k, acc_cyc - prev_rc, FLUSH_CYCLES + 1);
                end
            end
            wait_resp(rc);
            prev_rc = rc;
            checks++; if (r_valid !== (4'b0001 << exp_g[k])) begin
                errors++; $display("FAIL rr_owner[%0d]: got %b want %b", k, r_valid, 4'b0001 << exp_g[k]);
            end
            checks++; if (r_result !== exp_res[exp_g[k]] || r_err !== 1'b0) begin
                errors++; $display("FAIL rr_result[%0d]: got %h err %b want %h err 0", k, r_result, r_err, exp_res[exp_g[k]]);
            end
        end
        tick();
    endtask

    task automatic test_unsupported();
        int g, rc;
        do_reset();
        set_req(2, 4'b0100, 32'h1234_5678, 32'h1, 32'h2);
        req_valid = 4'b0100;
        wait_accept(g);
        req_valid = '0;
        checks++; if (g !== 2) begin errors++; $display("FAIL unsup_grant: got %0d want 2", g); end
        wait_resp(rc);
        checks++; if (rc - acc_cyc !== 1) begin errors++; $display("FAIL unsup_latency: got %0d want 1", rc - acc_cyc); end
        checks++; if (r_valid !== 4'b0100) begin errors++; $display("FAIL unsup_owner: got %b want 0100", r_valid); end
        checks++; if (r_err !== 1'b1 || r_result !== 32'h0) begin
            errors++; $display("FAIL unsup_err: got err %b result %h want err 1 result 0", r_err, r_result);
        end
        for (int i = 0; i < FLUSH_CYCLES + 3; i++) tick();
        checks++; if (en_seen !== 1'b0) begin errors++; $display("FAIL unsup_enable: got %b want 0", en_seen); end
    endtask

    task automatic test_timeout();
        int g, rc;
        do_reset();
        tie_low = 1;
        set_req(1, 4'd0, 32'h0001_0000, 32'h0, 32'h0000_8000);
        req_valid = 4'b0010;
        wait_accept(g);
        req_valid = '0;
        checks++; if (g !== 1) begin errors++; $display("FAIL to_grant: got %0d want 1", g); end
        wait_resp(rc);
        checks++; if (rc - acc_cyc !== TIMEOUT_CYCLES + 1) begin
            errors++; $display("FAIL to_latency: got %0d want %0d", rc - acc_cyc, TIMEOUT_CYCLES + 1);
        end
        checks++; if (r_valid !== 4'b0010 || r_err !== 1'b1 || r_result !== 32'h0) begin
            errors++; $display("FAIL to_resp: got valid %b err %b result %h want 0010 1 0", r_valid, r_err, r_result);
        end
        tick();
        checks++; if (busy !== 1'b1 || unit_enable !== 1'b0) begin
            errors++; $display("FAIL to_flush: got busy %b enable %b want 1 0", busy, unit_enable);
        end
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_flush_end: got busy %b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy %b want 0", busy); end
        tie_low = 0;
    endtask

    task automatic test_reset_mid_run();
        int g, rc, rc0;
        do_reset();
        lat = 18;
        set_req(3, 4'd8, 32'h0006_0000, 32'h0, 32'h0002_0000);
        req_valid = 4'b1000;
        wait_accept(g);
        req_valid = '0;
        checks++; if (g !== 3) begin errors++; $display("FAIL mid_grant: got %0d want 3", g); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (unit_enable !== 1'b1) begin errors++; $display("FAIL mid_running: got enable %b want 1", unit_enable); end
        rc0 = resp_count;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || unit_enable !== 1'b0) begin
            errors++; $display("FAIL mid_state: got busy %b enable %b want 0 0", busy, unit_enable);
        end
        checks++; if (unit_operation !== 4'b1111) begin errors++; $display("FAIL mid_op: got %b want 1111", unit_operation); end
        for (int i = 0; i < 25; i++) tick();
        checks++; if (resp_count !== rc0) begin errors++; $display("FAIL mid_no_resp: got %0d responses want 0", resp_count - rc0); end
        lat = 3;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'd7, 32'h0001_0000, 32'h0, 32'h0001_0000);
        req_valid = 4'b1111;
        wait_accept(g);
        req_valid = '0;
        checks++; if (g !== 0) begin errors++; $display("FAIL mid_next_grant: got %0d want 0", g); end
        wait_resp(rc);
        tick();
    endtask

    task automatic test_flush();
        int g, rc, rc0;
        do_reset();
        lat = 4;
        set_req(0, 4'd10, 32'h0001_0000, 32'h0, 32'h0000_0001);
        req_valid = 4'b0001;
        wait_accept(g);
        req_valid = '0;
        wait_resp(rc);
        checks++; if (rc - acc_cyc !== 5) begin errors++; $display("FAIL fl_latency: got %0d want 5", rc - acc_cyc); end
        checks++; if (r_result !== 32'hA5A4_0001 || r_err !== 1'b0) begin
            errors++; $display("FAIL fl_result: got %h err %b want a5a40001 err 0", r_result, r_err);
        end
        hold_done = 1;
        tick();
        rc0 = resp_count;
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            checks++; if (unit_enable !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL fl_hold[%0d]: got enable %b busy %b want 0 1", i, unit_enable, busy);
            end
            tick();
        end
        checks++; if (busy !== 1'b0 || unit_enable !== 1'b0) begin
            errors++; $display("FAIL fl_idle: got busy %b enable %b want 0 0", busy, unit_enable);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++; if (resp_count !== rc0) begin errors++; $display("FAIL fl_spurious: got %0d extra responses want 0", resp_count - rc0); end
        hold_done = 0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;
        req_z     = '0;
        test_reset();
        test_single_job();
        test_contention();
        test_unsupported();
        test_timeout();
        test_reset_mid_run();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/cordic_job_arbiter.md
Name: cordic_job_arbiter

Overview:
- Shares one CORDIC calculation unit (the top-level calc: enable/operation/x/y/z in, result/done out) between NUM_REQ independent requesters.
- Accepts jobs by round-robin arbitration and latches each job's operands.
- Holds the unit enabled until it reports done, then returns the result to the owning requester.
- Guards against a hung unit with a timeout, rejects unsupported operation codes without using the unit, and flushes the unit between jobs.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- WIDTH, 32, operand/result width (Q16.16 signed).
- TIMEOUT_CYCLES, 64, maximum cycles in RUN before a job is aborted with error.
- FLUSH_CYCLES, 2, cycles unit_enable is held low after every job.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot accept strobe; a job transfers when req_valid[i] & req_ready[i].
- req_op  in  4*NUM_REQ  operation code, slice i = [4i+3:4i].
- req_x  in  WIDTH*NUM_REQ  x operands, slice i.
- req_y  in  WIDTH*NUM_REQ  y operands, slice i.
- req_z  in  WIDTH*NUM_REQ  z operands, slice i.
- resp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to the job owner.
- resp_result  out  WIDTH  result, meaningful only while any resp_valid bit is high.
- resp_err  out  1  error flag qualifying resp_valid (unsupported op or timeout).
- busy  out  1  high in every state except IDLE.
- unit_enable  out  1  enable to the calc unit.
- unit_operation  out  4  operation code to the calc unit.
- unit_x  out  WIDTH  operand to the calc unit.
- unit_y  out  WIDTH  operand to the calc unit.
- unit_z  out  WIDTH  operand to the calc unit.
- unit_result  in  WIDTH  calc unit result.
- unit_done  in  1  calc unit completion.

Behaviour:
- Reset is rst, synchronous, active-high; it overrides everything, including a mid-job reset.
  - All registered outputs reset to 0 except unit_operation = 4'b1111.
  - State = IDLE, rr_ptr = NUM_REQ-1 (requester 0 wins first), timeout counter = 0.
  - A job in flight at reset is dropped with no response; the calc unit shares rst.
- States: IDLE, RUN, RESP, FLUSH.
- IDLE:
  - If any req_valid is high, grant the first requester searching from rr_ptr+1 upward, modulo NUM_REQ.
  - req_ready[g] is combinational, high only in IDLE and only for g; on that edge latch op/x/y/z of g into unit_operation/unit_x/unit_y/unit_z, and set rr_ptr = g.
  - Supported ops: SIN 0, COS 1, MULT 7, DIV 8, SINH 9, COSH 10. Supported -> RUN with counter = 0.
  - Any other code -> RESP with resp_err = 1, resp_result = 0; the unit is never enabled for it.
- RUN:
  - unit_enable = 1; operands stay stable for the whole job.
  - unit_done sampled high -> capture unit_result, resp_err = 0, go to RESP.
  - Otherwise, counter == TIMEOUT_CYCLES-1 -> resp_result = 0, resp_err = 1, go to RESP.
  - done on the final count cycle wins over timeout.
- RESP:
  - resp_valid[g] = 1 for exactly one cycle, no backpressure, then go to FLUSH.
  - unit_enable is 0 from this cycle onward.
- FLUSH:
  - unit_enable = 0 for FLUSH_CYCLES cycles so the unit's valid/done clears, then go to IDLE.
  - unit_done is ignored here and in IDLE.
- Latency:
  - Accept at cycle A; RUN from A+1; unit_done seen at cycle D gives resp_valid at D+1.
  - Unsupported op gives resp_valid at A+1.
  - Next accept no earlier than D+2+FLUSH_CYCLES.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 jobs.
- A requester dropping req_valid before acceptance simply loses its turn; requests never queue.

Test Plan:
- Single job: requester 0 MULT, x=0x00020000, z=0x00030000, unit done after 18 cycles -> resp_valid[0] 19 cycles after accept, resp_result = 0x00060000, resp_err = 0.
- Contention: all 4 requesters assert at once and hold -> accepts in order 0,1,2,3,0, each response going only to its owner bit.
- Unsupported op 4'b0100 on requester 2 -> resp_valid[2] one cycle after accept, resp_err = 1, result 0, unit_enable never high.
- Timeout: unit_done tied low -> resp_err = 1 exactly TIMEOUT_CYCLES+1 cycles after accept, then FLUSH, then IDLE.
- Reset mid-RUN: rst pulsed 5 cycles into a DIV job -> no resp_valid, busy = 0, unit_operation = 4'b1111, and the next accept grants requester 0.
- Flush check: unit_done held high after completion -> unit_enable stays low FLUSH_CYCLES cycles and no spurious second response occurs.
